// File: rtl/expansion_input_filter.sv
// Debounce and rise/fall edge detection for the expansion input word, sampled on a prescaled tick.
// Optional edge/flag outputs are built only when EXPANSION_FILTER_EDGE_EN is defined.
module expansion_input_filter #(
  parameter int WIDTH    = 8,
  parameter int DIVIDER  = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  input  logic             ack
);

  localparam int PW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [PW-1:0]             r_presc;
  logic                      w_tick;
  logic [WIDTH-1:0][CW-1:0]  r_cnt;
  logic [WIDTH-1:0]          r_data;
  logic [WIDTH-1:0]          w_accept;

  assign w_tick = (r_presc == PW'(DIVIDER - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // A bit is accepted on the tick that completes DEBOUNCE consecutive differing samples.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_accept[i] = w_tick && (data_in[i] != r_data[i]) && (r_cnt[i] == CW'(DEBOUNCE - 1));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (w_tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (data_in[i] == r_data[i]) begin
          r_cnt[i] <= '0;
        end else if (w_accept[i]) begin
          r_data[i] <= data_in[i];
          r_cnt[i]  <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign data_out = r_data;

`ifdef EXPANSION_FILTER_EDGE_EN
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;

  // New accepts take priority over a same-cycle ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_rise <= w_accept & data_in;
      r_fall <= w_accept & ~data_in;
      if (|w_accept) begin
        r_changed <= 1'b1;
      end else if (ack) begin
        r_changed <= 1'b0;
      end
    end
  end

  assign rise    = r_rise;
  assign fall    = r_fall;
  assign changed = r_changed;
`else
  logic w_unused;
  assign w_unused = ack;
  assign rise     = '0;
  assign fall     = '0;
  assign changed  = 1'b0;
`endif

endmodule

// File: tb/tb_expansion_input_filter.sv
// Directed bench for expansion_input_filter with WIDTH=8, DIVIDER=4, DEBOUNCE=3.
// Edge/flag expectations follow whether EXPANSION_FILTER_EDGE_EN is defined for the build.
module tb_expansion_input_filter;

`ifdef EXPANSION_FILTER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk;
  logic       reset_n;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic [7:0] rise;
  logic [7:0] fall;
  logic       changed;
  logic       ack;

  int n_checks = 0;
  int n_err    = 0;

  expansion_input_filter #(
    .WIDTH(8),
    .DIVIDER(4),
    .DEBOUNCE(3)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .data_out(data_out),
    .rise(rise),
    .fall(fall),
    .changed(changed),
    .ack(ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] e8(input logic [7:0] v);
    return EDGE ? v : 8'h00;
  endfunction

  initial begin
    reset_n = 1'b0;
    data_in = 8'hFF;
    ack     = 1'b0;

    edges(3);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_rise", rise, 8'h00);
    chk("rst_fall", fall, 8'h00);
    chk("rst_changed", {7'd0, changed}, 8'h00);

    // Accepted rise: ticks fall on edges 4, 8, 12 after release.
    data_in = 8'h03;
    reset_n = 1'b1;
    edges(11);
    chk("rise_pre_data", data_out, 8'h00);
    chk("rise_pre_rise", rise, 8'h00);
    edges(1);
    chk("rise_data", data_out, 8'h03);
    chk("rise_rise", rise, e8(8'h03));
    chk("rise_fall", fall, 8'h00);
    chk("rise_changed", {7'd0, changed}, e8(8'h01));
    edges(1);
    chk("rise_pulse_end", rise, 8'h00);
    chk("rise_changed_hold", {7'd0, changed}, e8(8'h01));

    // Glitch: bit 4 high for two ticks only.
    data_in = 8'h13;
    edges(7);
    data_in = 8'h03;
    edges(4);
    chk("glitch_data", data_out, 8'h03);
    chk("glitch_rise", rise, 8'h00);
    chk("glitch_changed", {7'd0, changed}, e8(8'h01));

    // Bit 4 high for three ticks is accepted.
    edges(4);
    chk("glitch_mid_data", data_out, 8'h03);
    data_in = 8'h13;
    edges(11);
    chk("b4_pre_data", data_out, 8'h03);
    edges(1);
    chk("b4_data", data_out, 8'h13);
    chk("b4_rise", rise, e8(8'h10));
    chk("b4_fall", fall, 8'h00);
    edges(1);
    chk("b4_pulse_end", rise, 8'h00);

    // Fall with ack in the accepting cycle: set wins.
    data_in = 8'h00;
    edges(10);
    chk("fall_pre_data", data_out, 8'h13);
    ack = 1'b1;
    edges(1);
    ack = 1'b0;
    chk("fall_data", data_out, 8'h00);
    chk("fall_fall", fall, e8(8'h13));
    chk("fall_rise", rise, 8'h00);
    chk("fall_ack_race_changed", {7'd0, changed}, e8(8'h01));
    edges(1);
    chk("fall_pulse_end", fall, 8'h00);
    ack = 1'b1;
    edges(1);
    ack = 1'b0;
    chk("lone_ack_changed", {7'd0, changed}, 8'h00);

    // Reset after two of three qualifying ticks discards progress.
    data_in = 8'h03;
    edges(6);
    chk("mid_pre_data", data_out, 8'h00);
    reset_n = 1'b0;
    edges(2);
    chk("mid_rst_data", data_out, 8'h00);
    chk("mid_rst_changed", {7'd0, changed}, 8'h00);
    reset_n = 1'b1;
    edges(4);
    chk("mid_after_1tick", data_out, 8'h00);
    edges(7);
    chk("mid_after_11", data_out, 8'h00);
    edges(1);
    chk("mid_after_12", data_out, 8'h03);
    chk("mid_rise", rise, e8(8'h03));

    // Asynchronous reset clears a live pulse without a clock edge.
    reset_n = 1'b0;
    #1;
    chk("async_rise", rise, 8'h00);
    chk("async_data", data_out, 8'h00);
    chk("async_changed", {7'd0, changed}, 8'h00);
    reset_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
